// File: rtl/sipo_byte_collector.sv
// Serial-in, parallel-out word assembler with a one-entry valid/ready output
// buffer and a sticky overrun flag for words that arrive while the buffer is
// still full.
//
// state | meaning
// EMPTY | output buffer holds no word, byte_valid low
// FULL  | output buffer holds a word, byte_valid high, byte_out stable
module sipo_byte_collector #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  input  logic                      sync,
  input  logic                      byte_ready,
  input  logic                      clr_ovr,
  output logic [DATA_W-1:0]         byte_out,
  output logic                      byte_valid,
  output logic [$clog2(DATA_W)-1:0] bit_count,
  output logic                      overrun
);

  localparam int            CW       = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W-1:0] base;
  logic [CW-1:0]     cnt_base;
  logic [DATA_W-1:0] word;
  logic              complete;

  // Collection path: sync restarts alignment before the current bit is taken,
  // so a bit arriving with sync becomes the first bit of a fresh word.
  always_comb begin
    base     = sync ? '0 : shift_q;
    cnt_base = sync ? '0 : cnt_q;
    if (MSB_FIRST) begin
      word = {base[DATA_W-2:0], bit_in};
    end else begin
      word = {bit_in, base[DATA_W-1:1]};
    end
    complete = bit_valid && (cnt_base == CNT_LAST);
    shift_d  = base;
    cnt_d    = cnt_base;
    if (bit_valid) begin
      if (complete) begin
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = word;
        cnt_d   = cnt_base + CW'(1);
      end
    end
  end

  // Output buffer next state; an overrun set overrides a same-cycle clear.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    if (clr_ovr) begin
      ovr_d = 1'b0;
    end
    case (state_q)
      EMPTY: begin
        if (complete) begin
          out_d   = word;
          state_d = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          if (byte_ready) begin
            out_d = word;
          end else begin
            ovr_d = 1'b1;
          end
        end else if (byte_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      shift_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovr_q   <= ovr_d;
    end
  end

  assign byte_out   = out_q;
  assign byte_valid = (state_q == FULL);
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_byte_collector.sv
// Bench for sipo_byte_collector: one MSB-first and one LSB-first instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_sipo_byte_collector;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0, bit_valid = 1'b0, sync = 1'b0, byte_ready = 1'b0, clr_ovr = 1'b0;

  logic [DW-1:0] out_m, out_l;
  logic          val_m, val_l, ovr_m, ovr_l;
  logic [2:0]    bc_m, bc_l;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit            q[$];
  logic          mv, mo;
  logic [DW-1:0] md_m, md_l;

  always #5 clk = ~clk;

  sipo_byte_collector #(.DATA_W(DW), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .byte_ready(byte_ready), .clr_ovr(clr_ovr), .byte_out(out_m),
    .byte_valid(val_m), .bit_count(bc_m), .overrun(ovr_m)
  );

  sipo_byte_collector #(.DATA_W(DW), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sync(sync),
    .byte_ready(byte_ready), .clr_ovr(clr_ovr), .byte_out(out_l),
    .byte_valid(val_l), .bit_count(bc_l), .overrun(ovr_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("msb_out",   32'(out_m), 32'(md_m));
    chk("msb_valid", 32'(val_m), 32'(mv));
    chk("msb_count", 32'(bc_m),  32'(q.size()));
    chk("msb_ovr",   32'(ovr_m), 32'(mo));
    chk("lsb_out",   32'(out_l), 32'(md_l));
    chk("lsb_valid", 32'(val_l), 32'(mv));
    chk("lsb_count", 32'(bc_l),  32'(q.size()));
    chk("lsb_ovr",   32'(ovr_l), 32'(mo));
  endtask

  task automatic model_reset();
    q.delete();
    mv   = 1'b0;
    mo   = 1'b0;
    md_m = '0;
    md_l = '0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check after it.
  task automatic step(input logic bv, input logic b, input logic s,
                      input logic rdy, input logic clr);
    logic          comp, ovset;
    logic [DW-1:0] wm, wl;
    bit_valid  = bv;
    bit_in     = b;
    sync       = s;
    byte_ready = rdy;
    clr_ovr    = clr;
    @(posedge clk);
    comp  = 1'b0;
    ovset = 1'b0;
    wm    = '0;
    wl    = '0;
    if (s) q.delete();
    if (bv) begin
      q.push_back(b);
      if (q.size() == DW) begin
        comp = 1'b1;
        for (int i = 0; i < DW; i++) begin
          wm[DW-1-i] = q[i];
          wl[i]      = q[i];
        end
        q.delete();
      end
    end
    if (comp) begin
      if (!mv || rdy) begin
        md_m = wm;
        md_l = wl;
        mv   = 1'b1;
      end else begin
        ovset = 1'b1;
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    if (ovset) mo = 1'b1;
    else if (clr) mo = 1'b0;
    #1;
    check_all();
  endtask

  // Sends a word MSB-first in time order, with optional random idle gaps.
  task automatic send_word(input logic [7:0] w, input logic rdy, input int gaps);
    int left = gaps;
    for (int i = 0; i < DW; i++) begin
      if (left > 0 && i > 0 && $urandom_range(0, 1) == 1) begin
        step(1'b0, 1'($urandom), 1'b0, rdy, 1'b0);
        left--;
      end
      step(1'b1, w[7-i], 1'b0, rdy, 1'b0);
    end
    while (left > 0) begin
      step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
      left--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_out", 32'(out_m), 32'h0);
    rst = 1'b0;

    // MSB-first assembly 0xA5 (LSB instance: reversed pattern, also 0xA5)
    pat = 8'hA5;
    for (int i = 0; i < DW; i++) begin
      step(1'b1, pat[7-i], 1'b0, 1'b1, 1'b0);
      chk("a5_count", 32'(bc_m), 32'((i + 1) % DW));
    end
    chk("a5_msb", 32'(out_m), 32'hA5);
    chk("a5_lsb", 32'(out_l), 32'hA5);
    chk("a5_valid", 32'(val_m), 32'h1);
    idle(1);
    chk("a5_drained", 32'(val_m), 32'h0);

    // bits 1,1,0,0,0,0,0,0
    send_word(8'hC0, 1'b1, 0);
    chk("c0_lsb", 32'(out_l), 32'h03);
    chk("c0_msb", 32'(out_m), 32'hC0);
    idle(1);

    // back-to-back words with gaps
    send_word(8'h3C, 1'b1, 3);
    send_word(8'hC3, 1'b1, 3);
    idle(2);
    chk("gap_no_ovr", 32'(ovr_m), 32'h0);

    // overrun
    send_word(8'h11, 1'b0, 0);
    send_word(8'h22, 1'b0, 0);
    chk("ovr_hold", 32'(out_m), 32'h11);
    chk("ovr_set", 32'(ovr_m), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_drain", 32'(val_m), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_clr", 32'(ovr_m), 32'h0);

    // simultaneous accept and complete
    send_word(8'h55, 1'b0, 0);
    pat = 8'hAA;
    for (int i = 0; i < DW; i++) step(1'b1, pat[7-i], 1'b0, (i == DW - 1), 1'b0);
    chk("sim_out", 32'(out_m), 32'hAA);
    chk("sim_valid", 32'(val_m), 32'h1);
    chk("sim_ovr", 32'(ovr_m), 32'h0);
    idle(1);

    // sync restarts alignment
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sync_count", 32'(bc_m), 32'h1);
    pat = 8'h01;
    for (int i = 1; i < DW; i++) step(1'b1, pat[7-i], 1'b0, 1'b0, 1'b0);
    chk("sync_out", 32'(out_m), 32'h81);
    idle(1);

    // clr_ovr together with a new overrun: set wins
    send_word(8'h0F, 1'b0, 0);
    pat = 8'hF0;
    for (int i = 0; i < DW; i++) step(1'b1, pat[7-i], 1'b0, 1'b0, (i == DW - 1));
    chk("clr_vs_set", 32'(ovr_m), 32'h1);
    chk("clr_vs_set_out", 32'(out_m), 32'h0F);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // asynchronous reset mid-word with buffer full
    send_word(8'h77, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bc_m), 32'h5);
    chk("pre_rst_valid", 32'(val_m), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_rst_out", 32'(out_m), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(8'h5A, 1'b0, 0);
    chk("post_rst_out", 32'(out_m), 32'h5A);
    chk("post_rst_lsb", 32'(out_l), 32'h5A);
    idle(1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 31) == 0),
           1'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
